// File: rtl/com_pkg.sv
// Shared definitions for the command/data ethernet TX arbiter.
package com_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_SEND     = 3'd2,
    ST_WAIT_LOW = 3'd3,
    ST_ACK      = 3'd4
  } state_t;

  localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd50000;

endpackage

// File: rtl/com_rr2.sv
// Two-way round-robin pick: a lone request always wins, a tie goes to the requester not served last.
module com_rr2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/com_arb.sv
// Arbitrates data/reply senders onto the ethernet TX four-phase handshake; fs_eth_send rises 2 cycles after a sampled request.
// Optional TX watchdog under COM_ARB_TIMEOUT_EN; requests arriving while busy are held by the requester until served.
module com_arb
  import com_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int          ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs_data,
  output logic              fd_data,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [ADDR_W-1:0] data_len,
  input  logic              fs_rply,
  output logic              fd_rply,
  input  logic [ADDR_W-1:0] rply_addr,
  input  logic [ADDR_W-1:0] rply_len,
  output logic              fs_eth_send,
  input  logic              fd_eth_send,
  output logic [ADDR_W-1:0] tx_addr,
  output logic [ADDR_W-1:0] tx_len,
  output logic              grant,
  output logic              busy,
  output logic              err_to
);

  state_t            r_state;
  logic              r_last;
  logic              r_grant;
  logic              r_fs_eth_send;
  logic              r_fd_data;
  logic              r_fd_rply;
  logic              r_err_to;
  logic [ADDR_W-1:0] r_tx_addr;
  logic [ADDR_W-1:0] r_tx_len;
  logic [1:0]        w_gnt;
  logic              w_to;

  com_rr2 u_rr2 (
    .i_req  ({fs_rply, fs_data}),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

`ifdef COM_ARB_TIMEOUT_EN
  logic [15:0] r_to_cnt;

  assign w_to = ((r_state == ST_SEND) || (r_state == ST_WAIT_LOW)) &&
                (r_to_cnt == TIMEOUT_CYC - 16'd1);

  // Counts only while staying in SEND/WAIT_LOW, so every state entry starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (((r_state == ST_SEND) && !fd_eth_send && !w_to) ||
                 ((r_state == ST_WAIT_LOW) && fd_eth_send && !w_to)) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end else begin
      r_to_cnt <= '0;
    end
  end
`else
  // Watchdog compiled out; the parameter is referenced only to keep it part of the interface.
  assign w_to = 1'b0 & (|TIMEOUT_CYC);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_last        <= 1'b1;
      r_grant       <= 1'b0;
      r_fs_eth_send <= 1'b0;
      r_fd_data     <= 1'b0;
      r_fd_rply     <= 1'b0;
      r_err_to      <= 1'b0;
      r_tx_addr     <= '0;
      r_tx_len      <= '0;
    end else begin
      r_err_to <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_grant <= w_gnt[1];
            r_state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          r_tx_addr     <= r_grant ? rply_addr : data_addr;
          r_tx_len      <= r_grant ? rply_len  : data_len;
          r_fs_eth_send <= 1'b1;
          r_state       <= ST_SEND;
        end
        ST_SEND: begin
          if (fd_eth_send) begin
            r_fs_eth_send <= 1'b0;
            r_state       <= ST_WAIT_LOW;
          end else if (w_to) begin
            r_fs_eth_send <= 1'b0;
            r_err_to      <= 1'b1;
            r_fd_data     <= ~r_grant;
            r_fd_rply     <= r_grant;
            r_state       <= ST_ACK;
          end
        end
        ST_WAIT_LOW: begin
          if (!fd_eth_send || w_to) begin
            r_err_to  <= w_to & fd_eth_send;
            r_fd_data <= ~r_grant;
            r_fd_rply <= r_grant;
            r_state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (r_grant ? !fs_rply : !fs_data) begin
            r_fd_data <= 1'b0;
            r_fd_rply <= 1'b0;
            r_last    <= r_grant;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fs_eth_send = r_fs_eth_send;
  assign fd_data     = r_fd_data;
  assign fd_rply     = r_fd_rply;
  assign tx_addr     = r_tx_addr;
  assign tx_len      = r_tx_len;
  assign grant       = r_grant;
  assign busy        = (r_state != ST_IDLE);
  assign err_to      = r_err_to;

endmodule

// File: tb/tb_com_arb.sv
// Bench for com_arb: requester/TX-engine models around the DUT, scoreboard of expected grant/addr/len per TX pulse.
module tb_com_arb;

  localparam int          AW = 16;
  localparam logic [15:0] TO = 16'd100;

  typedef struct packed {
    logic          g;
    logic [AW-1:0] a;
    logic [AW-1:0] l;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          fs_data, fd_data, fs_rply, fd_rply;
  logic          fs_eth_send, fd_eth_send, grant, busy, err_to;
  logic [AW-1:0] data_addr, data_len, rply_addr, rply_len, tx_addr, tx_len;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   pulses  = 0;
  int   tx_delay = 20;
  int   tx_cnt  = 0;
  bit   tx_hang = 1'b0;
  logic mon_prev = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  com_arb #(.TIMEOUT_CYC(TO), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .fs_data(fs_data), .fd_data(fd_data), .data_addr(data_addr), .data_len(data_len),
    .fs_rply(fs_rply), .fd_rply(fd_rply), .rply_addr(rply_addr), .rply_len(rply_len),
    .fs_eth_send(fs_eth_send), .fd_eth_send(fd_eth_send),
    .tx_addr(tx_addr), .tx_len(tx_len), .grant(grant), .busy(busy), .err_to(err_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ethernet TX engine: answers fs_eth_send after tx_delay cycles, holds done until start drops.
  initial begin
    fd_eth_send = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !fs_eth_send) begin
        fd_eth_send = 1'b0;
        tx_cnt = 0;
      end else if (!fd_eth_send && !tx_hang) begin
        tx_cnt++;
        if (tx_cnt >= tx_delay) fd_eth_send = 1'b1;
      end
    end
  end

  // Scoreboard consumer: one entry per rising edge of fs_eth_send; also polices fd vs grant.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (fs_eth_send === 1'b1 && mon_prev !== 1'b1) begin
        pulses++;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty: unexpected TX pulse g=%0d addr=%h len=%0d", grant, tx_addr, tx_len);
        end else begin
          mon_e = sb.pop_front();
          if ({grant, tx_addr, tx_len} !== mon_e) begin
            n_fail++;
            $display("FAIL sb_tx: got g=%0d addr=%h len=%0d, want g=%0d addr=%h len=%0d",
                     grant, tx_addr, tx_len, mon_e.g, mon_e.a, mon_e.l);
          end
        end
      end
      if (fd_data === 1'b1 || fd_rply === 1'b1) begin
        n_tests++;
        if ((fd_data && fd_rply) || (fd_data && grant) || (fd_rply && !grant)) begin
          n_fail++;
          $display("FAIL fd_owner: fd_data=%0d fd_rply=%0d grant=%0d", fd_data, fd_rply, grant);
        end
      end
      mon_prev = fs_eth_send;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got %0d failures so far, want completion", n_fail);
    $fatal(1, "time limit");
  end

  task automatic do_reset();
    rst = 1'b1;
    fs_data = 1'b0; fs_rply = 1'b0;
    data_addr = '0; data_len = '0; rply_addr = '0; rply_len = '0;
    tx_hang = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Four-phase requester: raise fs, wait fd (bounded), drop fs, wait fd low.
  task automatic req_txn(input bit who, input logic [AW-1:0] a, input logic [AW-1:0] l, output bit ok);
    ok = 1'b0;
    if (who) begin rply_addr = a; rply_len = l; fs_rply = 1'b1; end
    else     begin data_addr = a; data_len = l; fs_data = 1'b1; end
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ((who ? fd_rply : fd_data) === 1'b1) begin ok = 1'b1; break; end
    end
    if (who) fs_rply = 1'b0; else fs_data = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ((who ? fd_rply : fd_data) === 1'b0) break;
    end
  endtask

  task automatic test_reset();
    bit bad;
    rst = 1'b1;
    fs_data = 1'b0; fs_rply = 1'b0;
    data_addr = '0; data_len = '0; rply_addr = '0; rply_len = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({fs_eth_send, fd_data, fd_rply, tx_addr, tx_len, grant, busy, err_to} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got fs=%b fdd=%b fdr=%b a=%h l=%h g=%b busy=%b err=%b, want all 0",
               fs_eth_send, fd_data, fd_rply, tx_addr, tx_len, grant, busy, err_to);
    end
    rst = 1'b0;
    bad = 1'b0;
    repeat (4) begin @(negedge clk); if (busy !== 1'b0) bad = 1'b1; end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL reset_idle: busy went high without request, want 0"); end
  endtask

  task automatic test_single();
    bit seen;
    do_reset();
    tx_delay = 20;
    sb.push_back({1'b0, 16'h0100, 16'd1024});
    data_addr = 16'h0100; data_len = 16'd1024; fs_data = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (fs_eth_send !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL lat_cycle1: fs_eth_send=%b busy=%b, want 0 1", fs_eth_send, busy);
    end
    @(posedge clk); #1;
    n_tests++;
    if (fs_eth_send !== 1'b1) begin
      n_fail++; $display("FAIL lat_cycle2: fs_eth_send=%b, want 1", fs_eth_send);
    end
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (fd_data === 1'b1) begin seen = 1'b1; break; end
    end
    n_tests++;
    if (!seen || fd_eth_send !== 1'b0 || fs_eth_send !== 1'b0 || fd_rply !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: seen=%b fd_eth=%b fs_eth=%b fd_rply=%b, want 1 0 0 0",
               seen, fd_eth_send, fs_eth_send, fd_rply);
    end
    fs_data = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || fd_data !== 1'b0) begin
      n_fail++; $display("FAIL single_release: busy=%b fd_data=%b, want 0 0", busy, fd_data);
    end
  endtask

  task automatic test_tie();
    bit ok0, ok1;
    do_reset();
    tx_delay = 5;
    sb.push_back({1'b0, 16'h1234, 16'd100});
    sb.push_back({1'b1, 16'h5678, 16'd200});
    fork
      req_txn(1'b0, 16'h1234, 16'd100, ok0);
      req_txn(1'b1, 16'h5678, 16'd200, ok1);
    join
    n_tests++;
    if (!ok0 || !ok1 || sb.size() != 0) begin
      n_fail++; $display("FAIL tie: done0=%b done1=%b left=%0d, want 1 1 0", ok0, ok1, sb.size());
    end
  endtask

  task automatic test_alternate();
    bit okd[2];
    bit okr[2];
    do_reset();
    tx_delay = 3;
    for (int i = 0; i < 2; i++) begin
      sb.push_back({1'b0, 16'(16'h0200 + i), 16'd64});
      sb.push_back({1'b1, 16'(16'h0A00 + i), 16'd96});
    end
    fork
      for (int i = 0; i < 2; i++) req_txn(1'b0, 16'(16'h0200 + i), 16'd64, okd[i]);
      for (int j = 0; j < 2; j++) req_txn(1'b1, 16'(16'h0A00 + j), 16'd96, okr[j]);
    join
    n_tests++;
    if (!(okd[0] && okd[1] && okr[0] && okr[1]) || sb.size() != 0) begin
      n_fail++;
      $display("FAIL alternate: done=%b%b%b%b left=%0d, want 1111 0", okd[0], okr[0], okd[1], okr[1], sb.size());
    end
  endtask

  task automatic test_defer();
    bit ok0, ok1, seen, stable;
    int p0;
    do_reset();
    tx_delay = 10;
    p0 = pulses;
    stable = 1'b0;
    sb.push_back({1'b0, 16'h0300, 16'd32});
    fork
      req_txn(1'b0, 16'h0300, 16'd32, ok0);
      begin
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (fs_eth_send === 1'b1) begin seen = 1'b1; break; end
        end
        sb.push_back({1'b1, 16'hFFFF, 16'd0});
        req_txn(1'b1, 16'hFFFF, 16'd0, ok1);
      end
      begin
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (fs_eth_send === 1'b1) break;
        end
        data_addr = 16'hDEAD; data_len = 16'd7;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (fd_data === 1'b1) begin
            stable = (tx_addr === 16'h0300) && (tx_len === 16'd32) && (grant === 1'b0);
            break;
          end
        end
      end
    join
    n_tests++;
    if (!seen || !ok0 || !ok1 || (pulses - p0) != 2 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL defer: seen=%b ok=%b%b pulses=%0d left=%0d, want 1 11 2 0",
               seen, ok0, ok1, pulses - p0, sb.size());
    end
    n_tests++;
    if (!stable) begin n_fail++; $display("FAIL hold_stable: tx fields changed after latch, want 0300/32/g0"); end
  endtask

  task automatic test_timeout();
    int hi, errs;
    bit done, ok;
    do_reset();
    tx_hang = 1'b1;
    tx_delay = 3;
    hi = 0; errs = 0; done = 1'b0;
    sb.push_back({1'b0, 16'h0400, 16'd8});
    data_addr = 16'h0400; data_len = 16'd8; fs_data = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (fs_eth_send === 1'b1) hi++;
      if (err_to === 1'b1) errs++;
      if (fd_data === 1'b1) begin done = 1'b1; break; end
    end
`ifdef COM_ARB_TIMEOUT_EN
    n_tests++;
    if (hi != int'(TO) || errs != 1 || !done || fs_eth_send !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: send_cycles=%0d err_pulses=%0d fd=%b, want %0d 1 1", hi, errs, done, TO);
    end
    fs_data = 1'b0;
    repeat (3) begin @(negedge clk); if (err_to === 1'b1) errs++; end
    n_tests++;
    if (errs != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_end: err_pulses=%0d busy=%b, want 1 0", errs, busy);
    end
    tx_hang = 1'b0;
`else
    n_tests++;
    if (done || errs != 0 || fs_eth_send !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL no_timeout: fd=%b err_pulses=%0d fs_eth=%b busy=%b, want 0 0 1 1",
               done, errs, fs_eth_send, busy);
    end
    fs_data = 1'b0;
    tx_hang = 1'b0;
    req_txn(1'b0, 16'h0400, 16'd8, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL no_timeout_finish: fd_data never rose, want 1"); end
`endif
  endtask

  task automatic test_reset_mid();
    bit seen, bad;
    do_reset();
    tx_delay = 50;
    sb.push_back({1'b0, 16'h0500, 16'd16});
    data_addr = 16'h0500; data_len = 16'd16; fs_data = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (fs_eth_send === 1'b1) begin seen = 1'b1; break; end
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (!seen || fs_eth_send !== 1'b0 || fd_data !== 1'b0 || fd_rply !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_send: seen=%b fs_eth=%b fd=%b%b busy=%b, want 1 0 00 0",
               seen, fs_eth_send, fd_data, fd_rply, busy);
    end
    fs_data = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tx_delay = 2;
    sb.push_back({1'b1, 16'h0600, 16'd4});
    rply_addr = 16'h0600; rply_len = 16'd4; fs_rply = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fd_rply === 1'b1) begin seen = 1'b1; break; end
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (!seen || fd_rply !== 1'b0 || fd_data !== 1'b0) begin
      n_fail++; $display("FAIL rst_ack: seen=%b fd_rply=%b fd_data=%b, want 1 0 0", seen, fd_rply, fd_data);
    end
    fs_rply = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (8) begin @(negedge clk); if (busy !== 1'b0 || fs_eth_send !== 1'b0) bad = 1'b1; end
    n_tests++;
    if (bad || sb.size() != 0) begin
      n_fail++; $display("FAIL rst_no_resume: activity=%b left=%0d, want 0 0", bad, sb.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    fs_data = 1'b0; fs_rply = 1'b0;
    data_addr = '0; data_len = '0; rply_addr = '0; rply_len = '0;
    test_reset();
    test_single();
    test_tie();
    test_alternate();
    test_defer();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
